// File: rtl/canvas_pkg.sv
// Shared geometry, state encodings and the saturating add used by the drawing canvas.
package canvas_pkg;

    localparam int GRID      = 28;
    localparam int CELL      = 14;
    localparam int ORG_X     = 200;
    localparam int ORG_Y     = 44;
    localparam int DEPTH     = 16;
    localparam int INC       = 2000;
    localparam int NEIGH_INC = 500;

    localparam int NCELL = GRID * GRID;
    localparam int CW    = $clog2(GRID);
    localparam int AW    = $clog2(NCELL);

    typedef enum logic [1:0] {IDLE, PAINT, CLEAR, DUMP} canvas_state_t;

    // Brush visiting order: centre first, then the four neighbours.
    typedef enum logic [2:0] {CTR, LFT, RGT, UP, DN} brush_step_t;

    // Add with clamp at full scale; the extra top bit catches the overflow.
    function automatic logic [DEPTH-1:0] sat_add(input logic [DEPTH-1:0] value,
                                                 input logic [DEPTH-1:0] inc);
        logic [DEPTH:0] sum;
        sum = {1'b0, value} + {1'b0, inc};
        return sum[DEPTH] ? {DEPTH{1'b1}} : sum[DEPTH-1:0];
    endfunction

endpackage

// File: rtl/canvas_px2cell.sv
// Maps one screen coordinate to a canvas cell number plus an in-range flag.
module canvas_px2cell #(
    parameter int ORG  = 0,
    parameter int CELL = 14,
    parameter int GRID = 28
) (
    input  logic [9:0]              coord_i,
    output logic                    in_range_o,
    output logic [$clog2(GRID)-1:0] cell_o
);

    localparam int IW = $clog2(GRID);

    // Range test plus a threshold chain that yields the cell number without a divider.
    always_comb begin
        in_range_o = (int'(coord_i) >= ORG) && (int'(coord_i) < ORG + GRID * CELL);
        cell_o     = '0;
        for (int k = 1; k < GRID; k++) begin
            if (int'(coord_i) >= ORG + k * CELL) begin
                cell_o = IW'(k);
            end
        end
    end

endmodule

// File: rtl/canvas_grid.sv
// Drawing canvas: brush painting, single-cycle clear, VGA pixel lookup and a row-major dump stream.
module canvas_grid
    import canvas_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_tick,
    input  logic [9:0]       pen_x,
    input  logic [9:0]       pen_y,
    input  logic             pen_down,
    input  logic             clear,
    input  logic [9:0]       draw_x,
    input  logic [9:0]       draw_y,
    output logic             pix_on,
    output logic [7:0]       pix_val,
    input  logic             dump_start,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [DEPTH-1:0] dump_data,
    output logic             dump_last,
    output logic             busy
);

    logic          pen_x_in, pen_y_in, draw_x_in, draw_y_in;
    logic [CW-1:0] pen_cx, pen_cy, draw_cx, draw_cy;

    canvas_px2cell #(.ORG(ORG_X), .CELL(CELL), .GRID(GRID)) u_pen_x (
        .coord_i(pen_x), .in_range_o(pen_x_in), .cell_o(pen_cx));
    canvas_px2cell #(.ORG(ORG_Y), .CELL(CELL), .GRID(GRID)) u_pen_y (
        .coord_i(pen_y), .in_range_o(pen_y_in), .cell_o(pen_cy));
    canvas_px2cell #(.ORG(ORG_X), .CELL(CELL), .GRID(GRID)) u_draw_x (
        .coord_i(draw_x), .in_range_o(draw_x_in), .cell_o(draw_cx));
    canvas_px2cell #(.ORG(ORG_Y), .CELL(CELL), .GRID(GRID)) u_draw_y (
        .coord_i(draw_y), .in_range_o(draw_y_in), .cell_o(draw_cy));

    canvas_state_t    state_q, state_d;
    brush_step_t      step_q, step_d;
    logic [CW-1:0]    pcx_q, pcx_d, pcy_q, pcy_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [DEPTH-1:0] cell_q [NCELL];
    logic             pix_on_q;
    logic [7:0]       pix_val_q;

    logic [4:0]       step_ok;
    logic             nxt_found;
    brush_step_t      nxt_step;
    logic [AW-1:0]    ctr_idx, wr_idx, draw_idx;
    logic [DEPTH-1:0] wr_inc;
    logic             wr_en;
    logic             draw_in;

    // Pick the next brush step whose target cell lies inside the grid.
    always_comb begin
        step_ok   = {pcy_q != CW'(GRID - 1), pcy_q != '0,
                     pcx_q != CW'(GRID - 1), pcx_q != '0, 1'b1};
        nxt_found = 1'b0;
        nxt_step  = CTR;
        for (int s = 4; s >= 1; s--) begin
            if (3'(s) > step_q && step_ok[3'(s)]) begin
                nxt_found = 1'b1;
                nxt_step  = brush_step_t'(3'(s));
            end
        end
    end

    // Address and increment of the cell touched by the current brush step.
    always_comb begin
        ctr_idx = AW'(pcy_q) * AW'(GRID) + AW'(pcx_q);
        wr_inc  = (step_q == CTR) ? DEPTH'(INC) : DEPTH'(NEIGH_INC);
        unique case (step_q)
            LFT:     wr_idx = ctr_idx - AW'(1);
            RGT:     wr_idx = ctr_idx + AW'(1);
            UP:      wr_idx = ctr_idx - AW'(GRID);
            DN:      wr_idx = ctr_idx + AW'(GRID);
            default: wr_idx = ctr_idx;
        endcase
    end

    // Next-state logic: arbitration in IDLE, brush sequencing, clear and dump handshake.
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        pcx_d   = pcx_q;
        pcy_d   = pcy_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d = CLEAR;
                end else if (dump_start) begin
                    state_d = DUMP;
                    cnt_d   = '0;
                end else if (frame_tick && pen_down && pen_x_in && pen_y_in) begin
                    state_d = PAINT;
                    step_d  = CTR;
                    pcx_d   = pen_cx;
                    pcy_d   = pen_cy;
                end
            end
            PAINT: begin
                if (clear) begin
                    state_d = CLEAR;
                end else begin
                    wr_en = 1'b1;
                    if (nxt_found) step_d  = nxt_step;
                    else           state_d = IDLE;
                end
            end
            CLEAR: begin
                state_d = clear ? CLEAR : IDLE;
            end
            DUMP: begin
                if (clear) begin
                    state_d = CLEAR;
                end else if (dump_ready) begin
                    if (cnt_q == AW'(NCELL - 1)) state_d = IDLE;
                    else                         cnt_d   = cnt_q + AW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            step_q  <= CTR;
            pcx_q   <= '0;
            pcy_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            pcx_q   <= pcx_d;
            pcy_q   <= pcy_d;
            cnt_q   <= cnt_d;
        end
    end

    // Cell storage: bulk clear or one saturating brush write per cycle.
    // NOTE: cells live in resettable flops rather than RAM because clear must zero all of them in one cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NCELL; i++) cell_q[i] <= '0;
        end else if (state_q == CLEAR) begin
            for (int i = 0; i < NCELL; i++) cell_q[i] <= '0;
        end else if (wr_en) begin
            cell_q[wr_idx] <= sat_add(cell_q[wr_idx], wr_inc);
        end
    end

    assign draw_in  = draw_x_in && draw_y_in;
    assign draw_idx = AW'(draw_cy) * AW'(GRID) + AW'(draw_cx);

    // Registered pixel lookup for the colour path, independent of the FSM.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pix_on_q  <= 1'b0;
            pix_val_q <= '0;
        end else begin
            pix_on_q  <= draw_in;
            pix_val_q <= draw_in ? cell_q[draw_idx][DEPTH-1 -: 8] : '0;
        end
    end

    assign pix_on     = pix_on_q;
    assign pix_val    = pix_val_q;
    assign dump_valid = (state_q == DUMP);
    assign dump_last  = dump_valid && (cnt_q == AW'(NCELL - 1));
    assign dump_data  = dump_valid ? cell_q[cnt_q] : '0;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_canvas_grid.sv
// Randomised bench for canvas_grid against an arithmetic image model.
module tb_canvas_grid;
    import canvas_pkg::*;

    localparam int MAXV = (1 << DEPTH) - 1;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             frame_tick = 1'b0;
    logic [9:0]       pen_x = '0;
    logic [9:0]       pen_y = '0;
    logic             pen_down = 1'b0;
    logic             clear = 1'b0;
    logic [9:0]       draw_x = '0;
    logic [9:0]       draw_y = '0;
    logic             pix_on;
    logic [7:0]       pix_val;
    logic             dump_start = 1'b0;
    logic             dump_valid;
    logic             dump_ready = 1'b0;
    logic [DEPTH-1:0] dump_data;
    logic             dump_last;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;
    int model [NCELL];

    canvas_grid dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .pen_x(pen_x), .pen_y(pen_y), .pen_down(pen_down), .clear(clear),
        .draw_x(draw_x), .draw_y(draw_y), .pix_on(pix_on), .pix_val(pix_val),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .dump_last(dump_last), .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic bit in_grid(input int x, input int y);
        return x >= ORG_X && x < ORG_X + GRID * CELL && y >= ORG_Y && y < ORG_Y + GRID * CELL;
    endfunction

    function automatic int cell_of(input int x, input int y);
        return ((y - ORG_Y) / CELL) * GRID + (x - ORG_X) / CELL;
    endfunction

    // Deposit on one cell if it exists; returns 1 when a write happens.
    function automatic int bump(input int cx, input int cy, input int inc);
        int i;
        if (cx < 0 || cx >= GRID || cy < 0 || cy >= GRID) return 0;
        i = cy * GRID + cx;
        model[i] = (model[i] + inc > MAXV) ? MAXV : model[i] + inc;
        return 1;
    endfunction

    // One brush stamp; returns the number of cell writes (= paint cycles).
    function automatic int model_paint(input int cx, input int cy);
        int n;
        n = bump(cx, cy, INC);
        n += bump(cx - 1, cy, NEIGH_INC);
        n += bump(cx + 1, cy, NEIGH_INC);
        n += bump(cx, cy - 1, NEIGH_INC);
        n += bump(cx, cy + 1, NEIGH_INC);
        return n;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NCELL; i++) model[i] = 0;
    endfunction

    task automatic do_paint(input int x, input int y, input bit down, input bit poke);
        int exp_len;
        int len;
        pen_x = 10'(x);
        pen_y = 10'(y);
        pen_down = down;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        exp_len = (down && in_grid(x, y)) ? model_paint((x - ORG_X) / CELL, (y - ORG_Y) / CELL) : 0;
        len = 0;
        while (busy && len < 20) begin
            len++;
            dump_start = poke && len == 1;
            frame_tick = poke && len == 1;
            step();
        end
        dump_start = 1'b0;
        frame_tick = 1'b0;
        check("paint_len", len, exp_len);
        if (poke) begin
            step();
            check("paint_ignore_req", busy, 0);
        end
    endtask

    task automatic check_pix(input int x, input int y);
        bit on;
        draw_x = 10'(x);
        draw_y = 10'(y);
        step();
        on = in_grid(x, y);
        check("pix_on", pix_on, on);
        check("pix_val", pix_val, on ? (model[cell_of(x, y)] >> (DEPTH - 8)) & 255 : 0);
    endtask

    task automatic run_dump(input bit toggle, input int clear_at);
        int beat;
        int cyc;
        bit have_held;
        logic [DEPTH-1:0] held;
        beat = 0;
        cyc = 0;
        have_held = 0;
        held = '0;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        while (beat < NCELL && cyc < 4000) begin
            if (beat == clear_at) begin
                clear = 1'b1;
                dump_ready = 1'b0;
                step();
                clear = 1'b0;
                check("clr_valid_drop", dump_valid, 0);
                check("clr_busy", busy, 1);
                step();
                check("clr_idle", busy, 0);
                model_clear();
                return;
            end
            dump_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            check("dump_valid", dump_valid, 1);
            if (!dump_valid) break;
            if (have_held) check("dump_hold", dump_data, held);
            check("dump_last", dump_last, beat == NCELL - 1);
            if (dump_ready) begin
                check("dump_data", dump_data, model[beat]);
                beat++;
                have_held = 0;
            end else begin
                held = dump_data;
                have_held = 1;
            end
            step();
            cyc++;
        end
        dump_ready = 1'b0;
        check("dump_beats", beat, NCELL);
        check("dump_end_valid", dump_valid, 0);
        check("dump_end_busy", busy, 0);
    endtask

    initial begin
        #12;
        check("rst_busy", busy, 0);
        check("rst_valid", dump_valid, 0);
        check("rst_last", dump_last, 0);
        check("rst_data", dump_data, 0);
        check("rst_pix_on", pix_on, 0);
        check("rst_pix_val", pix_val, 0);
        step();
        Reset = 1'b0;
        step();

        // Corner stamp: centre, right, down only.
        do_paint(200, 44, 1'b1, 1'b0);
        check_pix(214, 44);
        check_pix(199, 44);
        check_pix(200, 44);
        check_pix(200, 58);

        // Pens just outside the canvas never paint.
        do_paint(199, 100, 1'b1, 1'b0);
        do_paint(592, 100, 1'b1, 1'b0);

        // Saturation on the corner cell.
        for (int i = 0; i < 33; i++) do_paint(207, 51, 1'b1, 1'b0);
        check_pix(207, 51);
        check_pix(221, 51);

        // Random brush stamps, one with competing requests mid-paint.
        for (int i = 0; i < 24; i++) begin
            do_paint($urandom_range(600, 190), $urandom_range(450, 30),
                     1'($urandom_range(1, 0)), i == 5);
        end
        do_paint(400, 250, 1'b1, 1'b1);
        do_paint(587, 431, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++) check_pix($urandom_range(600, 190), $urandom_range(450, 30));

        run_dump(1'b1, -1);
        run_dump(1'b0, 100);
        check_pix(200, 44);
        check_pix(400, 250);
        run_dump(1'b0, -1);

        // Asynchronous reset in the middle of a paint.
        do_paint(300, 200, 1'b1, 1'b0);
        pen_x = 10'd300;
        pen_y = 10'd200;
        pen_down = 1'b1;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("pre_rst_busy", busy, 1);
        #2;
        Reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", dump_valid, 0);
        check("mid_rst_pix_on", pix_on, 0);
        check("mid_rst_pix_val", pix_val, 0);
        step();
        Reset = 1'b0;
        model_clear();
        check_pix(300, 200);
        run_dump(1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/canvas_grid.md
Name: canvas_grid

Overview:
Parametrised drawing canvas holding a GRID x GRID array of DEPTH-bit cell intensities, painted from a cursor position once per frame.
- Brush deposits INC on the centre cell and NEIGH_INC on its 4-neighbours, with saturating arithmetic.
- Read port 1: registered pixel lookup for the VGA colour path.
- Read port 2: valid/ready row-major stream that dumps the image into the MNIST network input buffer.

Parameters:
GRID, 28, cells per side
CELL, 14, screen pixels per cell side
ORG_X, 200, screen X of the canvas left edge
ORG_Y, 44, screen Y of the canvas top edge
DEPTH, 16, bits per cell intensity (must be >= 8)
INC, 2000, centre-cell increment per paint
NEIGH_INC, 500, 4-neighbour increment per paint

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per frame (vsync edge)
pen_x  in  10  cursor screen X
pen_y  in  10  cursor screen Y
pen_down  in  1  paint enable (mouse button)
clear  in  1  one-cycle request to zero all cells
draw_x  in  10  VGA beam X
draw_y  in  10  VGA beam Y
pix_on  out  1  beam inside canvas (registered)
pix_val  out  8  cell intensity bits [DEPTH-1:DEPTH-8] (registered)
dump_start  in  1  one-cycle request to stream the image
dump_valid  out  1  stream beat valid
dump_ready  in  1  downstream accepts beat
dump_data  out  DEPTH  cell intensity
dump_last  out  1  final beat (cell GRID*GRID-1)
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, active-high): all cells 0, FSM in IDLE, and all outputs 0.
- Cell mapping: cx = (x-ORG_X)/CELL and cy = (y-ORG_Y)/CELL. A position is in range iff ORG_X <= x < ORG_X+GRID*CELL and ORG_Y <= y < ORG_Y+GRID*CELL. Storage is row-major, index = cy*GRID+cx.
- FSM states: IDLE, PAINT, CLEAR, DUMP.
- IDLE: requests are evaluated with priority clear > dump_start > (frame_tick & pen_down & pen in range).
  - The pen cell (cx,cy) is latched when the FSM enters PAINT.
  - Requests that lose arbitration are dropped, not queued.
- PAINT: one write per cycle in the order centre, left, right, up, down. Out-of-grid neighbours are skipped without consuming a cycle.
  - Each write is cell <= min(cell + inc, 2^DEPTH-1), computed at DEPTH+1 bits.
  - The FSM returns to IDLE after the last write. Maximum length is 5 cycles.
  - clear during PAINT aborts the remaining writes and enters CLEAR.
  - frame_tick and dump_start during PAINT are ignored.
- CLEAR: all cells are zeroed in 1 cycle, then the FSM returns to IDLE. clear asserted in any state goes to CLEAR on the next edge.
- DUMP: a beat counter runs 0..GRID*GRID-1.
  - dump_valid=1 and dump_data = cell[counter]. dump_last=1 when counter = GRID*GRID-1.
  - The counter advances on valid & ready. data, valid and last hold stable while ready=0.
  - The beat with last & ready returns the FSM to IDLE, with dump_valid=0 the next cycle.
  - clear during DUMP drops dump_valid on the next edge (stream truncated, no last) and enters CLEAR.
  - frame_tick during DUMP is ignored, so the image is frozen during the dump.
- Pixel port:
  - Fixed latency of 1 cycle and independent of FSM state.
  - pix_on = draw position in range. pix_val = top 8 bits of the addressed cell, or 0 when out of range.
  - A value written on edge N is visible in pix_val after edge N+1.
- busy = (state != IDLE).

Decomposition:
- canvas_pkg:
  - state enum canvas_state_t {IDLE, PAINT, CLEAR, DUMP}
  - brush-step enum {CTR, LFT, RGT, UP, DN}
  - localparam NCELL = GRID*GRID
  - function sat_add(DEPTH value, DEPTH inc)
- Sub-module: canvas_px2cell. Combinational, parametrised by ORG, CELL and GRID. Maps a 10-bit coordinate to {in_range, cell index} using a compare chain (no divider). It is instantiated four times: pen_x, pen_y, draw_x, draw_y.

Test Plan:
- Pen (200,44) down, one frame_tick -> cell(0,0)=2000, (1,0)=500, (0,1)=500. Write sequence is 3 cycles and busy=1 for exactly 3 cycles.
- Pen (207,51) down, 33 frame_ticks -> cell(0,0)=65535 (saturated, no wrap) and (1,0)=16500.
- After the first test, draw (214,44) -> pix_on=1, pix_val=8'h01 one cycle later. Draw (199,44) -> pix_on=0, pix_val=0.
- Pen (199,100) or (592,100) with frame_tick -> no cell changes and busy stays 0.
- dump_start with dump_ready toggling 1,0 -> exactly 784 accepted beats in row-major order. dump_last only on beat 783. data is stable while ready=0. busy drops after the last handshake.
- clear at beat 100 of a dump -> dump_valid=0 next cycle, all cells 0 two cycles later, FSM back in IDLE. A Reset pulse mid-PAINT -> immediate zero state.
